// File: rtl/vga_fb_arbiter_if.sv
//==============================================================================
// Module   : vga_fb_arbiter_if
// Purpose  : Requester-side bus of the frame-buffer arbiter (write + read-back).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 12
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data, rd_valid
    );
endinterface

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
//==============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Single-port frame-buffer scheduler: one display slot per pixel
//            period, round-robin write/read-back sharing of the other cycles.
//            Optional macro FB_BLANK_SHARE_EN opens blanking slots to requesters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_fb_arbiter #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int SHIFT  = 2,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 15
) (
    input  wire                clk,
    input  wire                btnC,
    input  wire                clk_25_hi,
    input  wire  [9:0]         h_in,
    input  wire  [9:0]         v_in,
    input  wire                display,
    input  wire                hsync_in,
    input  wire                vsync_in,
    vga_fb_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [PIX_W-1:0]   mem_wdata,
    input  wire  [PIX_W-1:0]   mem_rdata,
    output logic [PIX_W-1:0]   rgb,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam logic [ADDR_W:0] c_pixels = (ADDR_W+1)'(IMG_W * IMG_H);

    typedef enum logic [1:0] {DT_NONE, DT_PIX, DT_BLANK} dtag_e;
    typedef enum logic [1:0] {RT_NONE, RT_READ, RT_OOR}  rtag_e;

    logic              r_slot;
    logic              r_rr_rd;
    dtag_e             r_dtag1, r_dtag2;
    rtag_e             r_rtag1, r_rtag2;
    logic [3:0]        r_hs, r_vs;

    logic              w_disp_slot;
    logic              w_blank_slot;
    logic              w_arb_open;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_disp_addr;

    assign w_disp_addr = ADDR_W'((32'(v_in) >> SHIFT) * IMG_W + (32'(h_in) >> SHIFT));
    assign w_wr_ok     = ({1'b0, bus.wr_addr} < c_pixels);
    assign w_rd_ok     = ({1'b0, bus.rd_addr} < c_pixels);

    always_comb begin
        w_disp_slot  = r_slot & display;
        w_blank_slot = r_slot & ~display;
`ifdef FB_BLANK_SHARE_EN
        w_arb_open   = ~w_disp_slot;
`else
        w_arb_open   = ~r_slot;
`endif
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        if (w_arb_open) begin
            // Pointer set means the read side wins the next contested cycle
            if (bus.wr_req && bus.rd_req) begin
                w_gnt_rd = r_rr_rd;
                w_gnt_wr = ~r_rr_rd;
            end else begin
                w_gnt_wr = bus.wr_req;
                w_gnt_rd = bus.rd_req;
            end
        end
    end

    assign bus.wr_ack = w_gnt_wr;
    assign bus.rd_ack = w_gnt_rd;
    assign hsync_out  = r_hs[3];
    assign vsync_out  = r_vs[3];

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            r_slot       <= 1'b0;
            r_rr_rd      <= 1'b0;
            r_dtag1      <= DT_NONE;
            r_dtag2      <= DT_NONE;
            r_rtag1      <= RT_NONE;
            r_rtag2      <= RT_NONE;
            r_hs         <= '0;
            r_vs         <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            rgb          <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            r_slot <= clk_25_hi;
            mem_we <= 1'b0;

            if (w_disp_slot) begin
                mem_addr <= w_disp_addr;
            end else if (w_gnt_wr) begin
                mem_addr  <= bus.wr_addr;
                mem_wdata <= bus.wr_data;
                mem_we    <= w_wr_ok;
            end else if (w_gnt_rd) begin
                mem_addr <= bus.rd_addr;
            end

            if (w_gnt_wr || w_gnt_rd) begin
                r_rr_rd <= ~r_rr_rd;
            end

            r_dtag1 <= w_disp_slot ? DT_PIX : (w_blank_slot ? DT_BLANK : DT_NONE);
            r_rtag1 <= w_gnt_rd ? (w_rd_ok ? RT_READ : RT_OOR) : RT_NONE;
            r_dtag2 <= r_dtag1;
            r_rtag2 <= r_rtag1;

            // Second tag stage lines up with RAM data for the grant two cycles back
            case (r_dtag2)
                DT_PIX:   rgb <= mem_rdata;
                DT_BLANK: rgb <= '0;
                default:  ;
            endcase

            bus.rd_valid <= (r_rtag2 != RT_NONE);
            case (r_rtag2)
                RT_READ: bus.rd_data <= mem_rdata;
                RT_OOR:  bus.rd_data <= '0;
                default: ;
            endcase

            r_hs <= {r_hs[2:0], hsync_in};
            r_vs <= {r_vs[2:0], vsync_in};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
//==============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Scoreboard bench for vga_fb_arbiter with a behavioural pixel RAM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

    localparam int NPIX = 19200;

    logic        clk = 1'b0;
    logic        btnC;
    logic        clk_25_hi;
    logic [9:0]  h_in, v_in;
    logic        display, hsync_in, vsync_in;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata, mem_rdata, rgb;
    logic        hsync_out, vsync_out;

    vga_fb_arbiter_if #(.ADDR_W(15), .PIX_W(12)) bus ();

    vga_fb_arbiter dut (
        .clk(clk), .btnC(btnC), .clk_25_hi(clk_25_hi),
        .h_in(h_in), .v_in(v_in), .display(display),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bus(bus),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    logic [11:0] ram [0:NPIX-1];
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < NPIX) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (int'(mem_addr) < NPIX) ? ram[mem_addr] : 12'hFFF;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Pixel strobe: high one clk in four; slot_now marks the cycle after it
    int   phase = 0;
    logic slot_now = 1'b0;
    initial begin
        clk_25_hi = 1'b0;
        forever begin
            @(posedge clk); #1;
            slot_now  = clk_25_hi;
            phase     = (phase + 1) % 4;
            clk_25_hi = (phase == 0);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct { int addr; int data; } wexp_t;
    typedef struct { int data; int cyc;  } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    always @(negedge clk) begin
        wexp_t w;
        rexp_t r;
        if (!btnC) begin
            if (bus.rd_valid) begin
                if (rq.size() == 0) chk("rd_valid_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("rd_data", int'(bus.rd_data), r.data);
                    chk("rd_latency", cyc_n, r.cyc);
                end
            end
            if (mem_we) begin
                if (wq.size() == 0) chk("mem_we_unexpected", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("mem_addr", int'(mem_addr), w.addr);
                    chk("mem_wdata", int'(mem_wdata), w.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (clk_25_hi) break;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_addr"},  int'(mem_addr), 0);
        chk({tag, "_mem_we"},    int'(mem_we), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_rgb"},       int'(rgb), 0);
        chk({tag, "_rd_data"},   int'(bus.rd_data), 0);
        chk({tag, "_rd_valid"},  int'(bus.rd_valid), 0);
        chk({tag, "_hsync"},     int'(hsync_out), 0);
        chk({tag, "_vsync"},     int'(vsync_out), 0);
    endtask

    task automatic do_write(input int addr, input int data);
        bit got = 1'b0;
        bus.wr_addr = 15'(addr); bus.wr_data = 12'(data); bus.wr_req = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            #2;
            if (bus.wr_ack) begin
                got = 1'b1;
                chk("wr_ack_in_slot", int'(slot_now), 0);
                if (addr < NPIX) wq.push_back('{addr, data});
            end
            tick();
        end
        bus.wr_req = 1'b0;
        if (!got) chk("wr_ack_timeout", 0, 1);
    endtask

    task automatic do_read(input int addr, input int exp);
        bit got = 1'b0;
        bus.rd_addr = 15'(addr); bus.rd_req = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            #2;
            if (bus.rd_ack) begin
                got = 1'b1;
                chk("rd_ack_in_slot", int'(slot_now), 0);
                rq.push_back('{exp, cyc_n + 3});
            end
            tick();
        end
        bus.rd_req = 1'b0;
        if (!got) chk("rd_ack_timeout", 0, 1);
    endtask

    // Both requesters raised (out-of-range addrs); the first grant must be write
    task automatic first_grant_is_write(input string tag);
        bit got = 1'b0;
        bus.wr_addr = 15'(NPIX); bus.rd_addr = 15'(NPIX + 1);
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            #2;
            if (bus.wr_ack || bus.rd_ack) begin
                got = 1'b1;
                chk({tag, "_wr_ack"}, int'(bus.wr_ack), 1);
                chk({tag, "_rd_ack"}, int'(bus.rd_ack), 0);
                if (bus.rd_ack) rq.push_back('{0, cyc_n + 3});
            end
            tick();
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        if (!got) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic disp_pixel(input int h, input int v, input int exp);
        wait_strobe();
        h_in = 10'(h); v_in = 10'(v); display = 1'b1;
        repeat (4) tick();
        chk("rgb_first", int'(rgb), exp);
        repeat (3) tick();
        chk("rgb_hold", int'(rgb), exp);
    endtask

    initial begin
        int acks, n_wr, n_rd, alt_err, last, expect_blank;
        btnC = 1'b1; h_in = 10'd100; v_in = 10'd100; display = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        for (int i = 0; i < NPIX; i++) ram[i] = 12'h000;
        ram[0] = 12'h0F0; ram[1] = 12'h123; ram[160] = 12'h456; ram[19199] = 12'h789;

        repeat (3) tick();
        check_zero("reset");
        btnC = 1'b0;
        tick();
        first_grant_is_write("rr_after_reset");

        do_write(5, 12'hABC);
        do_write(NPIX, 12'h111);
        tick();
        do_read(5, 12'hABC);
        do_read(NPIX, 0);
        do_read(1, 12'h123);
        repeat (4) tick();

        // Both held through active video: 3 grants per 4 clk, alternating
        wait_strobe();
        bus.wr_addr = 15'(NPIX); bus.rd_addr = 15'(NPIX + 1);
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        n_wr = 0; n_rd = 0; alt_err = 0; last = -1;
        for (int i = 0; i < 16; i++) begin
            #2;
            if ((bus.wr_ack || bus.rd_ack) && slot_now) alt_err++;
            if (bus.wr_ack && bus.rd_ack) alt_err++;
            if (bus.wr_ack) begin
                n_wr++;
                if (last == 0) alt_err++;
                last = 0;
            end
            if (bus.rd_ack) begin
                n_rd++;
                if (last == 1) alt_err++;
                last = 1;
                rq.push_back('{0, cyc_n + 3});
            end
            tick();
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        chk("cont_grants", n_wr + n_rd, 12);
        chk("cont_wr_grants", n_wr, 6);
        chk("cont_order_errors", alt_err, 0);
        repeat (6) tick();

        // Sync delay: 4 clk shift
        hsync_in = 1'b1; tick();
        hsync_in = 1'b0; vsync_in = 1'b1; tick();
        vsync_in = 1'b0; tick();
        chk("hsync_early", int'(hsync_out), 0);
        tick();
        chk("hsync_d4", int'(hsync_out), 1);
        chk("vsync_early", int'(vsync_out), 0);
        tick();
        chk("hsync_d5", int'(hsync_out), 0);
        chk("vsync_d4", int'(vsync_out), 1);

        disp_pixel(0, 0, 12'h0F0);
        disp_pixel(3, 3, 12'h0F0);
        disp_pixel(4, 0, 12'h123);
        disp_pixel(0, 4, 12'h456);
        disp_pixel(639, 479, 12'h789);

        // Mid-frame reset right after a contested write grant (pointer now favours read)
        hsync_in = 1'b1; vsync_in = 1'b1;
        bus.wr_addr = 15'(NPIX); bus.rd_addr = 15'(NPIX + 1);
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 12 && acks == 0; i++) begin
            #2;
            if (bus.wr_ack) acks = 1;
            tick();
        end
        chk("pre_reset_wr_ack", acks, 1);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; btnC = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        tick(); tick();
        check_zero("mid_reset");
        btnC = 1'b0;
        tick();
        first_grant_is_write("rr_after_mid_reset");
        repeat (6) tick();

        disp_pixel(0, 4, 12'h456);

        // Blanking: requester acks per two pixel periods, rgb forced to 0
`ifdef FB_BLANK_SHARE_EN
        expect_blank = 8;
`else
        expect_blank = 6;
`endif
        wait_strobe();
        display = 1'b0; h_in = 10'd700; v_in = 10'd100;
        bus.wr_addr = 15'(NPIX); bus.wr_req = 1'b1;
        tick();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (bus.wr_ack) acks++;
            tick();
        end
        bus.wr_req = 1'b0;
        chk("blank_acks", acks, expect_blank);
        chk("blank_rgb", int'(rgb), 0);

        repeat (8) tick();
        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
